imm_extend_pipe: RTL

- Parametrised, pipelined successor to the combinational sign extender in the LEGv8 datapath.
- Decodes the instruction immediate field (Imm26 = instruction bits [25:0]) into a DATA_W-bit immediate for the I, D, B, CB and IW (MOVZ) formats.
- Carries each result through an elastic valid/ready pipeline of PIPE_DEPTH register stages.
- Sits between decode and the ALU-B mux / branch adder in the pipelined core. Flags illegal encodings and counts them.

---
 rtl/imm_extend_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate extender with an elastic valid/ready pipeline of PIPE_DEPTH stages.
// Decodes I/D/B/CB/IW immediates, flags illegal encodings and counts them (saturating).
module imm_extend_pipe #(
    parameter int DATA_W     = 64,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       Imm26,
    input  logic [2:0]        Ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] BusImm,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_D  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_CB = 3'b011;
    localparam logic [2:0] FMT_IW = 3'b100;
    localparam int         LAST   = PIPE_DEPTH - 1;

    logic [63:0]       w_full;
    logic [DATA_W-1:0] w_dec_data;
    logic              w_dec_err;
    logic              w_fire;

    logic [PIPE_DEPTH:0]   w_open;
    logic [PIPE_DEPTH-1:0] w_move;
    logic [PIPE_DEPTH-1:0] w_src_valid;
    logic [DATA_W-1:0]     w_src_data [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] w_src_err;

    logic [PIPE_DEPTH-1:0] r_valid;
    logic [DATA_W-1:0]     r_data [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] r_err;
    logic [CNT_W-1:0]      r_err_count;

    // Decode is computed at 64 bits and truncated, so B/CB wrap naturally for DATA_W=32.
    always_comb begin
        w_full    = '0;
        w_dec_err = 1'b0;
        case (Ctrl)
            FMT_I:  w_full = {52'b0, Imm26[21:10]};
            FMT_D:  w_full = {{55{Imm26[20]}}, Imm26[20:12]};
            FMT_B:  w_full = {{36{Imm26[25]}}, Imm26, 2'b00};
            FMT_CB: w_full = {{43{Imm26[23]}}, Imm26[23:5], 2'b00};
            FMT_IW: begin
                if (DATA_W == 32 && Imm26[22]) begin
                    w_dec_err = 1'b1;
                end else begin
                    w_full = {48'b0, Imm26[20:5]} << {Imm26[22:21], 4'b0000};
                end
            end
            default: w_dec_err = 1'b1;
        endcase
        w_dec_data = w_dec_err ? '0 : w_full[DATA_W-1:0];
    end

    // Ready ripples backwards from the consumer; a full stage whose successor opens
    // this cycle is itself open, so a full pipeline still streams without bubbles.
    always_comb begin
        w_open             = '0;
        w_move             = '0;
        w_open[PIPE_DEPTH] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            w_move[k] = r_valid[k] && w_open[k+1];
            w_open[k] = !r_valid[k] || w_move[k];
        end
    end

    assign in_ready = w_open[0] || flush;
    assign w_fire   = in_valid && w_open[0] && !flush;

    always_comb begin
        w_src_valid    = '0;
        w_src_err      = '0;
        w_src_valid[0] = w_fire;
        w_src_data[0]  = w_dec_data;
        w_src_err[0]   = w_dec_err;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            w_src_valid[k] = w_move[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_err[k]   = r_err[k-1];
        end
    end

    // NOTE: stage data is reset too, because reset must force every stage's contents to zero,
    // not only the valid bits; sequential state uses non-blocking assignments throughout.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (w_open[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_src_data[k];
                        r_err[k]  <= w_src_err[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_err_count <= '0;
        end else if (w_fire && w_dec_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    // Empty stages may hold stale data, so the output is gated by the last valid bit.
    assign out_valid = r_valid[LAST];
    assign BusImm    = out_valid ? r_data[LAST] : '0;
    assign out_err   = out_valid && r_err[LAST];
    assign err_count = r_err_count;

endmodule
